// File: rtl/pwm_fade_pkg.sv
// Shared types and register-map constants for the PWM fade sequencer.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_CTR   = 3'd1,
    WAIT_CTR = 3'd2,
    WR_PW    = 3'd3,
    WAIT_PW  = 3'd4,
    HOLD     = 3'd5,
    DONE     = 3'd6
  } fade_state_e;

  // Byte offset of the counter register inside a channel block.
  localparam int unsigned PwCtrOffset = 4;
  // Byte distance between consecutive channel blocks.
  localparam int unsigned ChanStride  = 8;

endpackage

// File: rtl/pwm_fade_step.sv
// Saturating next-level calculator for the fade ramp. Arithmetic is done one
// bit wider than the level so neither direction can wrap; a zero step moves by 1.
module pwm_fade_step #(
  parameter int unsigned CtrSize = 8
) (
  input  logic [CtrSize-1:0] cur_i,
  input  logic [CtrSize-1:0] step_i,
  input  logic [CtrSize-1:0] end_i,
  input  logic               up_i,
  output logic [CtrSize-1:0] next_o,
  output logic               reached_end_o
);

  logic [CtrSize:0] cur_x;
  logic [CtrSize:0] step_x;
  logic [CtrSize:0] end_x;
  logic [CtrSize:0] sum_x;
  logic [CtrSize:0] floor_x;
  logic [CtrSize:0] diff_x;

  // Clamp toward the end level in whichever direction the fade is moving.
  always_comb begin
    cur_x   = {1'b0, cur_i};
    end_x   = {1'b0, end_i};
    step_x  = (step_i == '0) ? {{CtrSize{1'b0}}, 1'b1} : {1'b0, step_i};
    sum_x   = cur_x + step_x;
    floor_x = end_x + step_x;
    diff_x  = cur_x - step_x;
    next_o  = end_i;
    if (up_i) begin
      if (sum_x < end_x) next_o = sum_x[CtrSize-1:0];
    end else begin
      // cur - step stays above end only when cur > end + step; no underflow possible.
      if (cur_x > floor_x) next_o = diff_x[CtrSize-1:0];
    end
  end

  assign reached_end_o = (cur_i == end_i);

endmodule

// File: rtl/pwm_fade_master.sv
// Bus-master fade sequencer driving the PWM wrapper write port.
// Optional build macro PWM_FADE_LOOP_EN: ping-pong between the two levels
// until stopped instead of finishing at the end level.
//
// state    | meaning
// IDLE     | waiting for start_i
// WR_CTR   | counter-register write request on the bus
// WAIT_CTR | waiting for counter write completion
// WR_PW    | pulse-width write request on the bus
// WAIT_PW  | waiting for pulse-width write completion
// HOLD     | down-counting step_period before the next level
// DONE     | one-cycle done pulse, then back to IDLE
module pwm_fade_master
  import pwm_fade_pkg::*;
#(
  parameter int unsigned CtrSize     = 8,
  parameter int unsigned ChanWidth   = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned PwmBaseAddr = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [ChanWidth-1:0] channel_i,
  input  logic [CtrSize-1:0]   max_counter_i,
  input  logic [CtrSize-1:0]   start_level_i,
  input  logic [CtrSize-1:0]   end_level_i,
  input  logic [CtrSize-1:0]   step_i,
  input  logic [15:0]          step_period_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CtrSize-1:0]   cur_level_o,
  output logic                 pwm_req_o,
  output logic [AddrWidth-1:0] pwm_addr_o,
  output logic                 pwm_we_o,
  output logic [3:0]           pwm_be_o,
  output logic [DataWidth-1:0] pwm_wdata_o,
  input  logic                 pwm_rvalid_i
);

  fade_state_e          state_q;
  logic [ChanWidth-1:0] chan_q;
  logic [CtrSize-1:0]   start_q;
  logic [CtrSize-1:0]   end_q;
  logic [CtrSize-1:0]   step_q;
  logic [CtrSize-1:0]   wr_level_q;
  logic [15:0]          period_q;
  logic [15:0]          timer_q;
  logic                 up_q;
  logic                 stop_pend_q;
  logic                 stop_now;
  logic [CtrSize-1:0]   next_level;
  logic                 at_end;
  logic [AddrWidth-1:0] ctr_addr_cmd;
  logic [AddrWidth-1:0] pw_addr;

  // Counter address comes from the live command inputs (issued on the latch cycle);
  // pulse-width address comes from the latched channel.
  assign ctr_addr_cmd = AddrWidth'(PwmBaseAddr) + AddrWidth'(channel_i) * AddrWidth'(ChanStride)
                        + AddrWidth'(PwCtrOffset);
  assign pw_addr      = AddrWidth'(PwmBaseAddr) + AddrWidth'(chan_q) * AddrWidth'(ChanStride);
  assign stop_now     = stop_pend_q | stop_i;
  assign pwm_we_o     = pwm_req_o;
  assign pwm_be_o     = 4'hF;

  pwm_fade_step #(.CtrSize(CtrSize)) u_step (
    .cur_i        (wr_level_q),
    .step_i       (step_q),
    .end_i        (end_q),
    .up_i         (up_q),
    .next_o       (next_level),
    .reached_end_o(at_end)
  );

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      step_q      <= '0;
      wr_level_q  <= '0;
      period_q    <= '0;
      timer_q     <= '0;
      up_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cur_level_o <= '0;
      pwm_req_o   <= 1'b0;
      pwm_addr_o  <= '0;
      pwm_wdata_o <= '0;
    end else begin
      pwm_req_o <= 1'b0;
      done_o    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            chan_q      <= channel_i;
            start_q     <= start_level_i;
            end_q       <= end_level_i;
            step_q      <= step_i;
            period_q    <= step_period_i;
            up_q        <= (end_level_i >= start_level_i);
            stop_pend_q <= 1'b0;
            busy_o      <= 1'b1;
            pwm_req_o   <= 1'b1;
            pwm_addr_o  <= ctr_addr_cmd;
            pwm_wdata_o <= DataWidth'(max_counter_i);
            state_q     <= WR_CTR;
          end
        end
        WR_CTR: begin
          if (stop_i) stop_pend_q <= 1'b1;
          state_q <= WAIT_CTR;
        end
        WAIT_CTR: begin
          if (pwm_rvalid_i) begin
            if (stop_now) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              pwm_req_o   <= 1'b1;
              pwm_addr_o  <= pw_addr;
              pwm_wdata_o <= DataWidth'(start_q);
              wr_level_q  <= start_q;
              state_q     <= WR_PW;
            end
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end
        WR_PW: begin
          if (stop_i) stop_pend_q <= 1'b1;
          state_q <= WAIT_PW;
        end
        WAIT_PW: begin
          if (pwm_rvalid_i) begin
            cur_level_o <= wr_level_q;
            timer_q     <= period_q;
`ifdef PWM_FADE_LOOP_EN
            if (stop_now) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Bounce: the level just reached becomes the new start.
              if (at_end) begin
                start_q <= end_q;
                end_q   <= start_q;
                up_q    <= ~up_q;
              end
              state_q <= HOLD;
            end
`else
            if (stop_now || at_end) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= HOLD;
            end
`endif
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end
        HOLD: begin
          if (stop_i) begin
            done_o  <= 1'b1;
            state_q <= DONE;
          end else if (timer_q == '0) begin
            pwm_req_o   <= 1'b1;
            pwm_addr_o  <= pw_addr;
            pwm_wdata_o <= DataWidth'(next_level);
            wr_level_q  <= next_level;
            state_q     <= WR_PW;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
